// File: rtl/sort_frame_loader_if.sv
// Word stream in, held 4-word frame out; slave = loader, master = feeder/consumer side.
interface sort_frame_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             mode_out;
  logic             frame_valid;
  logic             frame_ack;
  logic [2:0]       fill_cnt;
  logic             pad_flag;

  modport slave (
    input  in_data, in_mode, in_valid, frame_ack,
    output in_ready, a, b, c, d, mode_out, frame_valid, fill_cnt, pad_flag
  );

  modport master (
    output in_data, in_mode, in_valid, frame_ack,
    input  in_ready, a, b, c, d, mode_out, frame_valid, fill_cnt, pad_flag
  );
endinterface

// File: rtl/sort_frame_loader.sv
// Packs 4 words into a held sorter frame; frame_valid 1 edge after 4th word, in_ready low while FULL until acked.
// FRAME_TIMEOUT_EN: a partial frame idle for TIMEOUT_CYC cycles is padded so pads sort to the tail.
module sort_frame_loader #(
  parameter int WIDTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_frame_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0][WIDTH-1:0]     frame_q, frame_d;
  logic                      mode_q, mode_d;
  logic [2:0]                fill_q, fill_d;
  logic                      pad_q, pad_d;
  logic                      in_ready;
  logic                      xfer;
  logic                      ack;
  logic                      timeout;
  logic [WIDTH-1:0]          pad_word;

  assign xfer     = bus.in_valid & in_ready;
  assign ack      = bus.frame_ack & (state_q == FULL);
  assign pad_word = mode_q ? '0 : '1;

`ifdef FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] idle_q, idle_d;

  // A transfer on the expiry edge takes priority over padding.
  assign timeout = (state_q == FILL) && !xfer && (idle_q == TO_LAST);

  always_comb begin
    idle_d = '0;
    if (state_q == FILL && !xfer) begin
      idle_d = idle_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = FILL;
      FILL: if ((xfer && fill_q == 3'd3) || timeout) state_d = FULL;
      FULL: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from registered state only
  always_comb begin
    in_ready        = (state_q != FULL);
    bus.in_ready    = in_ready;
    bus.frame_valid = (state_q == FULL);
  end

  always_comb begin
    frame_d = frame_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    pad_d   = pad_q;
    if (xfer) begin
      frame_d[fill_q[1:0]] = bus.in_data;
      if (state_q == IDLE) begin
        mode_d = bus.in_mode;
      end
      fill_d = fill_q + 3'd1;
    end else if (timeout) begin
      for (int i = 1; i < 4; i++) begin
        if (3'(i) >= fill_q) begin
          frame_d[i] = pad_word;
        end
      end
      fill_d = 3'd4;
      pad_d  = 1'b1;
    end else if (ack) begin
      fill_d = 3'd0;
      pad_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      mode_q  <= 1'b0;
      fill_q  <= 3'd0;
      pad_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      pad_q   <= pad_d;
    end
  end

  assign bus.a        = frame_q[0];
  assign bus.b        = frame_q[1];
  assign bus.c        = frame_q[2];
  assign bus.d        = frame_q[3];
  assign bus.mode_out = mode_q;
  assign bus.fill_cnt = fill_q;
  assign bus.pad_flag = pad_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader; build with +define+FRAME_TIMEOUT_EN to cover padding.
module tb_sort_frame_loader;
  localparam int WIDTH = 4;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sort_frame_loader_if #(.WIDTH(WIDTH)) bus ();

  sort_frame_loader #(.WIDTH(WIDTH), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w, input logic m);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_mode  = m;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] abcd, input logic m,
                           input logic fv, input logic [2:0] fc, input logic pf);
    check({tag, ".a"}, 32'(bus.a), 32'(abcd[15:12]));
    check({tag, ".b"}, 32'(bus.b), 32'(abcd[11:8]));
    check({tag, ".c"}, 32'(bus.c), 32'(abcd[7:4]));
    check({tag, ".d"}, 32'(bus.d), 32'(abcd[3:0]));
    check({tag, ".mode"}, 32'(bus.mode_out), 32'(m));
    check({tag, ".fv"}, 32'(bus.frame_valid), 32'(fv));
    check({tag, ".rdy"}, 32'(bus.in_ready), 32'(!fv));
    check({tag, ".fill"}, 32'(bus.fill_cnt), 32'(fc));
    check({tag, ".pad"}, 32'(bus.pad_flag), 32'(pf));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_mode   = 1'b0;
    bus.frame_ack = 1'b0;
    #2;
    chk_frame("rst", 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // 1: back-to-back frame, ascending
    send(4'h9, 1'b0);
    send(4'h3, 1'b0);
    send(4'hC, 1'b0);
    chk_frame("t1_3w", 16'h93C0, 1'b0, 1'b0, 3'd3, 1'b0);
    send(4'h1, 1'b0);
    chk_frame("t1_full", 16'h93C1, 1'b0, 1'b1, 3'd4, 1'b0);

    // 2: stall while FULL, then ack with in_valid still high
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h7;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.in_data = 4'(i + 2);
      bus.in_data = 4'h7;
    end
    chk_frame("t2_stall", 16'h93C1, 1'b0, 1'b1, 3'd4, 1'b0);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk_frame("t2_ack", 16'h93C1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk_frame("t2_cap", 16'h73C1, 1'b0, 1'b0, 3'd1, 1'b0);
    send(4'h2, 1'b1);
    send(4'h4, 1'b1);
    send(4'h6, 1'b1);
    chk_frame("t2_full", 16'h7246, 1'b0, 1'b1, 3'd4, 1'b0);
    ack_frame();

    // 3: only word 0 sets the mode
    send(4'hA, 1'b1);
    send(4'hB, 1'b0);
    send(4'h0, 1'b0);
    send(4'hF, 1'b0);
    chk_frame("t3", 16'hAB0F, 1'b1, 1'b1, 3'd4, 1'b0);
    ack_frame();

    // 4: async reset mid-frame discards the partial frame
    send(4'h5, 1'b1);
    send(4'h6, 1'b0);
    chk_frame("t4_pre", 16'h560F, 1'b1, 1'b0, 3'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk_frame("t4_rst", 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk_frame("t4_clean", 16'h1234, 1'b0, 1'b1, 3'd4, 1'b0);
    ack_frame();

    // 5: stray acks and valid gaps have no effect
    ack_frame();
    chk_frame("t5_idle_ack", 16'h1234, 1'b0, 1'b0, 3'd0, 1'b0);
    send(4'h8, 1'b1);
    bus.in_data = 4'hE;
    tick();
    ack_frame();
    chk_frame("t5_fill_ack", 16'h8234, 1'b1, 1'b0, 3'd1, 1'b0);
    send(4'h9, 1'b0);
    tick();
    send(4'hA, 1'b0);
    tick();
    tick();
    send(4'hB, 1'b0);
    chk_frame("t5_gaps", 16'h89AB, 1'b1, 1'b1, 3'd4, 1'b0);
    ack_frame();

`ifdef FRAME_TIMEOUT_EN
    // 6: timeout padding, ascending and descending, and transfer on the expiry edge
    send(4'h2, 1'b0);
    send(4'h8, 1'b0);
    repeat (TO - 1) tick();
    chk_frame("t6_pre", 16'h28AB, 1'b0, 1'b0, 3'd2, 1'b0);
    tick();
    chk_frame("t6_asc", 16'h28FF, 1'b0, 1'b1, 3'd4, 1'b1);
    ack_frame();
    check("t6_padclr", 32'(bus.pad_flag), 32'd0);

    send(4'h2, 1'b1);
    send(4'h8, 1'b0);
    repeat (TO) tick();
    chk_frame("t6_desc", 16'h2800, 1'b1, 1'b1, 3'd4, 1'b1);
    ack_frame();

    send(4'h2, 1'b0);
    send(4'h8, 1'b0);
    repeat (TO - 1) tick();
    send(4'h3, 1'b0);
    chk_frame("t6_edge", 16'h2830, 1'b0, 1'b0, 3'd3, 1'b0);
    repeat (TO) tick();
    chk_frame("t6_edge_pad", 16'h283F, 1'b0, 1'b1, 3'd4, 1'b1);
    ack_frame();
`else
    // 6: without the timeout a partial frame waits indefinitely
    send(4'h2, 1'b0);
    send(4'h8, 1'b0);
    repeat (2 * TO) tick();
    chk_frame("t6_nopad", 16'h28AB, 1'b0, 1'b0, 3'd2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
